// File: rtl/bcd_disp_encoder_pkg.sv
// Shared display constants and state type for the BCD entry and display encoder paths.
// Digit codes above 9 are interpreted by seven_seg as special glyphs.
package bcd_disp_encoder_pkg;

  localparam logic [3:0] OFF        = 4'hA;
  localparam logic [3:0] NEGATIVE   = 4'hB;
  localparam int         MAX_TENTHS = 999;
  localparam int         BCD_DIGITS = 3;

  localparam int BCD_W = 4 * BCD_DIGITS;
  localparam int BIN_W = 10;  // enough bits for MAX_TENTHS
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_t;

endpackage

// File: rtl/bcd_disp_encoder_add3_nibble.sv
// Double-dabble digit correction: a BCD nibble of 5 or more gets 3 added
// so that the following left shift carries into the next decimal digit.
module bcd_add3_nibble (
  input  logic [3:0] nibble_i,
  output logic [3:0] nibble_o
);

  always_comb begin
    nibble_o = (nibble_i >= 4'd5) ? nibble_i + 4'd3 : nibble_i;
  end

endmodule

// File: rtl/bcd_disp_encoder.sv
// Signed binary tenths reading to three BCD digits plus sign code for the
// seven_seg display, using a one-bit-per-clock shift-add-3 engine.
module bcd_disp_encoder
  import bcd_disp_encoder_pkg::*;
#(
  parameter int IN_W     = 11,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [IN_W-1:0] value,
  output logic            busy,
  output logic            done,
  output logic [3:0]      digit_0,
  output logic [3:0]      digit_1,
  output logic [3:0]      digit_2,
  output logic [3:0]      sign,
  output logic            ovf
);

  state_t state_q, state_d;

  logic [IN_W-1:0]  value_q, value_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [BCD_W-1:0] bcd_adj;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic             ovf_pend_q, ovf_pend_d;
  logic [3:0]       digit0_q, digit0_d;
  logic [3:0]       digit1_q, digit1_d;
  logic [3:0]       digit2_q, digit2_d;
  logic [3:0]       sign_q, sign_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic [IN_W-1:0]  mag;
  logic             mag_big;

  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_add3
    bcd_add3_nibble u_add3 (
      .nibble_i (bcd_q[4*g +: 4]),
      .nibble_o (bcd_adj[4*g +: 4])
    );
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    state_d = SHIFT;
      SHIFT:   if (cnt_q == CNT_W'(1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == LOAD) || (state_q == SHIFT);
  end

  // The two's-complement negation is IN_W wide, so the most negative input
  // yields its true magnitude as an unsigned number instead of wrapping.
  always_comb begin
    mag     = value_q[IN_W-1] ? (~value_q + IN_W'(1)) : value_q;
    mag_big = (mag > IN_W'(MAX_TENTHS));
  end

  // NOTE: every variable gets a hold default before the case so no path
  // leaves one unassigned, which would infer a latch.
  always_comb begin
    value_d    = value_q;
    bcd_d      = bcd_q;
    bin_d      = bin_q;
    cnt_d      = cnt_q;
    neg_d      = neg_q;
    ovf_pend_d = ovf_pend_q;
    digit0_d   = digit0_q;
    digit1_d   = digit1_q;
    digit2_d   = digit2_q;
    sign_d     = sign_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) value_d = value;
      end
      LOAD: begin
        bin_d      = mag_big ? BIN_W'(MAX_TENTHS) : mag[BIN_W-1:0];
        bcd_d      = '0;
        cnt_d      = CNT_W'(BIN_W);
        neg_d      = value_q[IN_W-1];
        ovf_pend_d = mag_big;
      end
      SHIFT: begin
        // The shifted-out MSB is always zero since the input never exceeds 999.
        {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
        cnt_d          = cnt_q - CNT_W'(1);
      end
      DONE: begin
        digit0_d = bcd_q[3:0];
        digit1_d = bcd_q[7:4];
        digit2_d = (BLANK_LZ && (bcd_q[11:8] == 4'd0)) ? OFF : bcd_q[11:8];
        sign_d   = neg_q ? NEGATIVE : OFF;
        ovf_d    = ovf_pend_q;
        done_d   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value_q    <= '0;
      bcd_q      <= '0;
      bin_q      <= '0;
      cnt_q      <= '0;
      neg_q      <= 1'b0;
      ovf_pend_q <= 1'b0;
      digit0_q   <= 4'd0;
      digit1_q   <= 4'd0;
      digit2_q   <= 4'd0;
      sign_q     <= OFF;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      value_q    <= value_d;
      bcd_q      <= bcd_d;
      bin_q      <= bin_d;
      cnt_q      <= cnt_d;
      neg_q      <= neg_d;
      ovf_pend_q <= ovf_pend_d;
      digit0_q   <= digit0_d;
      digit1_q   <= digit1_d;
      digit2_q   <= digit2_d;
      sign_q     <= sign_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
    end
  end

  assign done    = done_q;
  assign digit_0 = digit0_q;
  assign digit_1 = digit1_q;
  assign digit_2 = digit2_q;
  assign sign    = sign_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_bcd_disp_encoder.sv
// Testbench for bcd_disp_encoder: hand-written vector table, corner sequences
// and a full-range sweep, all checked through a done-driven scoreboard.
module tb_bcd_disp_encoder;
  import bcd_disp_encoder_pkg::*;

  localparam int IN_W = 11;

  typedef struct {
    int         value;
    logic [3:0] d0;
    logic [3:0] d1;
    logic [3:0] d2;     // BLANK_LZ=1 instance
    logic [3:0] d2_nb;  // BLANK_LZ=0 instance
    logic [3:0] sign;
    logic       ovf;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [IN_W-1:0] value;
  logic            busy, done, busy_nb, done_nb;
  logic [3:0]      d0, d1, d2, sign, d0_nb, d1_nb, d2_nb, sign_nb;
  logic            ovf, ovf_nb;

  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t sb_q[$];
  vec_t last;
  vec_t tbl[12];

  always #5 clk = ~clk;

  bcd_disp_encoder #(.IN_W(IN_W), .BLANK_LZ(1'b1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .value(value),
    .busy(busy), .done(done), .digit_0(d0), .digit_1(d1), .digit_2(d2),
    .sign(sign), .ovf(ovf)
  );

  bcd_disp_encoder #(.IN_W(IN_W), .BLANK_LZ(1'b0)) u_dut_nb (
    .clk(clk), .rst(rst), .start(start), .value(value),
    .busy(busy_nb), .done(done_nb), .digit_0(d0_nb), .digit_1(d1_nb), .digit_2(d2_nb),
    .sign(sign_nb), .ovf(ovf_nb)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t model(input int v);
    vec_t r;
    int   m;
    r.value = v;
    m       = (v < 0) ? -v : v;
    r.ovf   = (m > 999);
    if (m > 999) m = 999;
    r.d0    = 4'(m % 10);
    r.d1    = 4'((m / 10) % 10);
    r.d2_nb = 4'(m / 100);
    r.d2    = (m / 100 == 0) ? 4'hA : 4'(m / 100);
    r.sign  = (v < 0) ? 4'hB : 4'hA;
    return r;
  endfunction

  function automatic logic [31:0] pack_out(input vec_t e);
    return {11'd0, e.d0, e.d1, e.d2, e.sign, e.ovf, e.d2_nb};
  endfunction

  function automatic logic [31:0] pack_dut();
    return {11'd0, d0, d1, d2, sign, ovf, d2_nb};
  endfunction

  task automatic compare_result(input vec_t e);
    check($sformatf("d0[v=%0d]", e.value), d0, e.d0);
    check($sformatf("d1[v=%0d]", e.value), d1, e.d1);
    check($sformatf("d2[v=%0d]", e.value), d2, e.d2);
    check($sformatf("d2_noblank[v=%0d]", e.value), d2_nb, e.d2_nb);
    check($sformatf("sign[v=%0d]", e.value), sign, e.sign);
    check($sformatf("ovf[v=%0d]", e.value), ovf, e.ovf);
    check($sformatf("done_noblank[v=%0d]", e.value), done_nb, 1);
  endtask

  // Drives one conversion; optionally pulses start again extra_at cycles in.
  task automatic convert(input vec_t e, input int extra_at);
    int   cycles;
    bit   got;
    vec_t exp_r;
    @(negedge clk);
    value = IN_W'(e.value);
    start = 1'b1;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    start  = 1'b0;
    value  = ~value;
    cycles = 0;
    got    = 1'b0;
    while (!got && cycles < 40) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        check($sformatf("latency[v=%0d]", e.value), cycles, 12);
        if (sb_q.size() == 0) begin
          check("scoreboard_empty", 0, 1);
        end else begin
          exp_r = sb_q.pop_front();
          compare_result(exp_r);
          last = exp_r;
        end
      end else begin
        check($sformatf("busy[v=%0d,c=%0d]", e.value, cycles), busy, (cycles <= 10));
        check($sformatf("hold[v=%0d,c=%0d]", e.value, cycles), pack_dut(), pack_out(last));
      end
      start = (cycles == extra_at);
      if (cycles == extra_at) value = IN_W'(123);
      @(posedge clk);
      #1;
      cycles++;
    end
    start = 1'b0;
    if (!got) check($sformatf("done_timeout[v=%0d]", e.value), 0, 1);
    @(negedge clk);
    check($sformatf("done_pulse_width[v=%0d]", e.value), done, 0);
  endtask

  initial begin
    int extra;
    tbl[0]  = '{253,   4'd3, 4'd5, 4'd2, 4'd2, 4'hA, 1'b0};
    tbl[1]  = '{-47,   4'd7, 4'd4, 4'hA, 4'd0, 4'hB, 1'b0};
    tbl[2]  = '{1023,  4'd9, 4'd9, 4'd9, 4'd9, 4'hA, 1'b1};
    tbl[3]  = '{-1024, 4'd9, 4'd9, 4'd9, 4'd9, 4'hB, 1'b1};
    tbl[4]  = '{999,   4'd9, 4'd9, 4'd9, 4'd9, 4'hA, 1'b0};
    tbl[5]  = '{0,     4'd0, 4'd0, 4'hA, 4'd0, 4'hA, 1'b0};
    tbl[6]  = '{-999,  4'd9, 4'd9, 4'd9, 4'd9, 4'hB, 1'b0};
    tbl[7]  = '{100,   4'd0, 4'd0, 4'd1, 4'd1, 4'hA, 1'b0};
    tbl[8]  = '{-1000, 4'd9, 4'd9, 4'd9, 4'd9, 4'hB, 1'b1};
    tbl[9]  = '{1,     4'd1, 4'd0, 4'hA, 4'd0, 4'hA, 1'b0};
    tbl[10] = '{-5,    4'd5, 4'd0, 4'hA, 4'd0, 4'hB, 1'b0};
    tbl[11] = '{50,    4'd0, 4'd5, 4'hA, 4'd0, 4'hA, 1'b0};
    last    = '{0, 4'd0, 4'd0, 4'd0, 4'd0, 4'hA, 1'b0};

    rst   = 1'b0;
    start = 1'b0;
    value = '0;
    repeat (2) @(negedge clk);
    check("reset.busy", busy, 0);
    check("reset.done", done, 0);
    check("reset.outputs", pack_dut(), pack_out(last));
    rst = 1'b1;
    @(negedge clk);

    // 999 followed by 0 exercises output holding through a conversion.
    for (int i = 0; i < 12; i++) convert(tbl[i], -1);

    // A second start mid-conversion must be dropped, not queued.
    convert(model(321), 5);
    extra = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) extra++;
    end
    check("ignored_start.extra_done", extra, 0);
    convert(model(-678), -1);

    // Reset six cycles into a conversion aborts it with no done pulse.
    @(negedge clk);
    value = IN_W'(500);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    last = '{0, 4'd0, 4'd0, 4'd0, 4'd0, 4'hA, 1'b0};
    check("midreset.busy", busy, 0);
    check("midreset.done", done, 0);
    check("midreset.outputs", pack_dut(), pack_out(last));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) extra++;
    end
    check("midreset.no_done", extra, 0);
    check("midreset.outputs_after", pack_dut(), pack_out(last));
    convert(model(500), -1);

    for (int v = -1024; v <= 1023; v++) convert(model(v), -1);

    check("scoreboard_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_disp_encoder.md
Name: bcd_disp_encoder

Overview:
- Converts a signed binary reading into the three-digit BCD plus sign-code form consumed by the seven_seg display instances (HEX0..HEX3). The value is in tenths of a unit, e.g. 253 = 25.3.
- Mirror of the switch-driven BCD entry path: entry turns keyed digits into stored digits, this block turns a binary number back into digits.
- Uses a sequential shift-add-3 (double-dabble) engine, one bit per clock, with a start/done handshake.

Parameters:
- IN_W, 11, width of the two's-complement input `value`; must be >= 11.
- BLANK_LZ, 1, when 1 the tens digit shows OFF (4'hA) instead of 0 when it is zero.

Ports:
- clk  input  1  system clock (CLOCK_50 domain)
- rst  input  1  reset, asynchronous, active-low
- start  input  1  single-cycle request; sampled only in IDLE
- value  input  IN_W  signed two's-complement reading in tenths; captured when start is accepted
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse; outputs are valid on and after this cycle
- digit_0  output  4  tenths BCD digit
- digit_1  output  4  units BCD digit
- digit_2  output  4  tens BCD digit, or 4'hA when blanked
- sign  output  4  4'hB (NEGATIVE) if value < 0, else 4'hA (OFF)
- ovf  output  1  high when |value| > 999 and the result was saturated

Behaviour:
- Reset (rst low, async): state IDLE; busy=0, done=0, ovf=0; digit_0=digit_1=digit_2=0; sign=4'hA. The internal shift register and counter are cleared.
- State IDLE: if start=1, capture value into an input register and go to LOAD. Otherwise stay.
- State LOAD (1 cycle):
  - mag = |value| as IN_W-bit unsigned; abs of the most negative value must not wrap.
  - If mag > 999: mag := 999 and set pending ovf.
  - Load the 10 LSBs of mag into the shift register; clear the 12-bit BCD accumulator; bit counter := 10.
  - Record pending sign.
- State SHIFT (10 cycles): each cycle, add 3 to any BCD nibble >= 5, then shift the {bcd, bin} register left by 1 and decrement the counter. Go to DONE when the counter reaches 0.
- State DONE (1 cycle):
  - Register digit_0/1/2 from the accumulator, applying BLANK_LZ to digit_2.
  - Register sign and ovf; done=1; return to IDLE.
- Latency: start sampled at edge N gives done high in the cycle after edge N+12. busy is high during LOAD and SHIFT and low in DONE.
- Output holding: digits, sign and ovf change only in DONE. They hold the previous result throughout a conversion, so the display never flickers.
- start while busy or in DONE: ignored, not queued.
- value changes after capture: no effect on the conversion in flight.
- Zero: digits 0,0,(blank or 0); sign OFF. Negative zero cannot occur.
- Reset mid-conversion: immediate abort; all outputs return to reset values; no done pulse.
- Digit range: only codes 0-9 and 4'hA are ever driven on digit outputs.

Decomposition:
- Shared package (also used by the BCD entry path):
  - OFF = 4'hA, NEGATIVE = 4'hB
  - MAX_TENTHS = 999, BCD_DIGITS = 3
  - state enum IDLE/LOAD/SHIFT/DONE
- One natural sub-module: bcd_add3_nibble, the combinational ">=5 then +3" correction, instantiated once per digit. The FSM, counter and register live in the top.

Test Plan:
- Reset then value=253, start -> done exactly 12 cycles later; digits 3,5,2; sign 4'hA; ovf=0.
- value=-47 (11-bit 0x7D1), BLANK_LZ=1 -> digit_0=7, digit_1=4, digit_2=4'hA, sign=4'hB, ovf=0. With BLANK_LZ=0 -> digit_2=0.
- value=1023 and value=-1024 -> digits 9,9,9; ovf=1; sign 4'hA and 4'hB respectively.
- Convert 999, then start with 0 -> digits stay 9,9,9 until the DONE cycle, then become 0,0,(A); no intermediate values.
- start pulsed again 5 cycles into a conversion -> ignored; exactly one done pulse. The next start after done converts normally.
- rst asserted at cycle 6 of a conversion of 500 -> outputs return to reset values immediately; no done. After release, a new conversion of 500 -> 0,0,5.
- Exhaustive sweep -1024..1023 -> digits match decimal of the clamped |value|; sign and ovf correct.
